// File: rtl/dumbrv_spi_write.sv
// SPI mode-0 write master for 23xx serial SRAM: WRITE, 16-bit address, one byte.
// Sequential follow-on writes stream inside the same chip-select frame.
module dumbrv_spi_write #(
    parameter int HOLD_CYCLES = 8,
    parameter int CS_GAP      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_sck,
    input  logic        valid_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        busy_o
);

    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES);
    localparam logic [GW-1:0] GAP_LD  = GW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_CMD, S_ADRH, S_ADRL, S_DATA, S_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          phase_q, phase_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          addr_vld_q, addr_vld_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;

    logic shifting;
    logic byte_end;
    logic accept;
    logic seq_hit;

    assign shifting = (state_q == S_CMD) || (state_q == S_ADRH) ||
                      (state_q == S_ADRL) || (state_q == S_DATA);
    assign byte_end = shifting && phase_q && (bitcnt_q == 3'd7);
    assign ready_o  = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign accept   = valid_i && ready_o;
    // 17-bit compare so 0xFFFF never chains into 0x0000
    assign seq_hit  = addr_vld_q &&
                      ({1'b0, addr_i} == ({1'b0, addr_q} + 17'd1));

    assign spi_cs_n = !(shifting || (state_q == S_HOLD));
    assign spi_sck  = shifting && phase_q;
    assign spi_mosi = shifting && shreg_q[7];
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = done_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        phase_d    = phase_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        addr_vld_d = addr_vld_q;
        pend_d     = pend_q;
        done_d     = 1'b0;

        if (shifting) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                shreg_d  = {shreg_q[6:0], 1'b0};
                bitcnt_d = bitcnt_q + 3'd1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d     = addr_i;
                    data_d     = data_i;
                    addr_vld_d = 1'b1;
                    state_d    = S_CMD;
                    shreg_d    = 8'h02;
                    bitcnt_d   = 3'd0;
                    phase_d    = 1'b0;
                end
            end
            S_CMD: begin
                if (byte_end) begin
                    state_d = S_ADRH;
                    shreg_d = addr_q[15:8];
                end
            end
            S_ADRH: begin
                if (byte_end) begin
                    state_d = S_ADRL;
                    shreg_d = addr_q[7:0];
                end
            end
            S_ADRL: begin
                if (byte_end) begin
                    state_d = S_DATA;
                    shreg_d = data_q;
                end
            end
            S_DATA: begin
                if (byte_end) begin
                    done_d = 1'b1;
                    if (HOLD_CYCLES > 0) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = HOLD_LD;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LD;
                    end
                end
            end
            S_HOLD: begin
                if (accept) begin
                    addr_d = addr_i;
                    data_d = data_i;
                    if (seq_hit) begin
                        state_d  = S_DATA;
                        shreg_d  = data_i;
                        bitcnt_d = 3'd0;
                        phase_d  = 1'b0;
                    end else begin
                        state_d   = S_GAP;
                        pend_d    = 1'b1;
                        gap_cnt_d = GAP_LD;
                    end
                end else if (hold_cnt_q == '0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LD;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (pend_q) begin
                        state_d  = S_CMD;
                        pend_d   = 1'b0;
                        shreg_d  = 8'h02;
                        bitcnt_d = 3'd0;
                        phase_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= 8'h00;
            bitcnt_q   <= 3'd0;
            phase_q    <= 1'b0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            addr_q     <= 16'h0000;
            data_q     <= 8'h00;
            addr_vld_q <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            phase_q    <= phase_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            addr_vld_q <= addr_vld_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_dumbrv_spi_write.sv
// Bench for dumbrv_spi_write: one instance streaming (HOLD_CYCLES=8),
// one with streaming disabled (HOLD_CYCLES=0).
module tb_dumbrv_spi_write;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid_a = 1'b0;
    logic [15:0] addr_a = '0;
    logic [7:0]  data_a = '0;
    logic        mosi_a, cs_a, sck_a, ready_a, done_a, busy_a;

    logic        valid_b = 1'b0;
    logic [15:0] addr_b = '0;
    logic [7:0]  data_b = '0;
    logic        mosi_b, cs_b, sck_b, ready_b, done_b, busy_b;

    dumbrv_spi_write #(.HOLD_CYCLES(8), .CS_GAP(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .spi_mosi(mosi_a), .spi_cs_n(cs_a), .spi_sck(sck_a),
        .valid_i(valid_a), .addr_i(addr_a), .data_i(data_a),
        .ready_o(ready_a), .done_o(done_a), .busy_o(busy_a)
    );

    dumbrv_spi_write #(.HOLD_CYCLES(0), .CS_GAP(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .spi_mosi(mosi_b), .spi_cs_n(cs_b), .spi_sck(sck_b),
        .valid_i(valid_b), .addr_i(addr_b), .data_i(data_b),
        .ready_o(ready_b), .done_o(done_b), .busy_o(busy_b)
    );

    int errors = 0;
    int checks = 0;
    int ncyc = 0;

    logic bits_a[$];
    int   fall_a[$], rise_a[$], dn_a[$];
    logic bits_b[$];
    int   fall_b[$], rise_b[$], dn_b[$];
    logic psck_a = 1'b0, pcs_a = 1'b1;
    logic psck_b = 1'b0, pcs_b = 1'b1;

    // Negedge monitor: SRAM-side view of both buses
    initial forever begin
        @(negedge clk);
        ncyc++;
        if (sck_a && !psck_a) bits_a.push_back(mosi_a);
        if (!cs_a && pcs_a) fall_a.push_back(ncyc);
        if (cs_a && !pcs_a) rise_a.push_back(ncyc);
        if (done_a) dn_a.push_back(ncyc);
        if (sck_b && !psck_b) bits_b.push_back(mosi_b);
        if (!cs_b && pcs_b) fall_b.push_back(ncyc);
        if (cs_b && !pcs_b) rise_b.push_back(ncyc);
        if (done_b) dn_b.push_back(ncyc);
        psck_a = sck_a; pcs_a = cs_a;
        psck_b = sck_b; pcs_b = cs_b;
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_a(input int s, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[30:0], bits_a[s+i]};
        return r;
    endfunction

    function automatic logic [31:0] pack_b(input int s, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[30:0], bits_b[s+i]};
        return r;
    endfunction

    task automatic clear_all();
        bits_a.delete(); fall_a.delete(); rise_a.delete(); dn_a.delete();
        bits_b.delete(); fall_b.delete(); rise_b.delete(); dn_b.delete();
    endtask

    // Returns acc = monitor cycle number of the first period after accept
    task automatic req_a(input logic [15:0] ad, input logic [7:0] dt,
                         output int acc);
        int n = 0;
        @(negedge clk);
        valid_a = 1'b1; addr_a = ad; data_a = dt;
        #1;
        while (!ready_a && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (!ready_a) begin
            chk("req_a_timeout", 1, 0);
            valid_a = 1'b0;
            acc = -1000;
        end else begin
            @(posedge clk); #1;
            valid_a = 1'b0;
            acc = ncyc + 1;
        end
    endtask

    task automatic req_b(input logic [15:0] ad, input logic [7:0] dt,
                         output int acc);
        int n = 0;
        @(negedge clk);
        valid_b = 1'b1; addr_b = ad; data_b = dt;
        #1;
        while (!ready_b && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (!ready_b) begin
            chk("req_b_timeout", 1, 0);
            valid_b = 1'b0;
            acc = -1000;
        end else begin
            @(posedge clk); #1;
            valid_b = 1'b0;
            acc = ncyc + 1;
        end
    endtask

    task automatic wait_idle_a(output int at);
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (busy_a && n < 400);
        chk("idle_a_timeout", busy_a, 0);
        at = ncyc;
    endtask

    task automatic wait_idle_b();
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (busy_b && n < 400);
        chk("idle_b_timeout", busy_b, 0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int a1, a2, t, rdy;
        vecs[0] = '{16'h1234, 8'hA5, 32'h021234A5};
        vecs[1] = '{16'h0000, 8'h00, 32'h02000000};
        vecs[2] = '{16'hFFFF, 8'hFF, 32'h02FFFFFF};
        vecs[3] = '{16'h8001, 8'h5A, 32'h0280015A};

        #2;
        chk("rst_cs_n", cs_a, 1);
        chk("rst_sck", sck_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_ready", ready_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_busy", busy_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh frames, each ending by HOLD timeout
        for (int i = 0; i < 4; i++) begin
            clear_all();
            req_a(vecs[i].addr, vecs[i].data, a1);
            wait_idle_a(t);
            chk("fr_nbits", bits_a.size(), 32);
            chk("fr_word", pack_a(0, 32), vecs[i].word);
            chk("fr_cs_fall", fall_a.size() > 0 ? fall_a[0] - a1 + 1 : -1, 1);
            chk("fr_ndone", dn_a.size(), 1);
            chk("fr_done_t", dn_a.size() > 0 ? dn_a[0] - a1 + 1 : -1, 65);
            chk("fr_cs_rise", rise_a.size() > 0 ? rise_a[0] - a1 + 1 : -1, 74);
            chk("fr_busy_low", t - a1 + 1, 76);
        end

        // Sequential follow-on streams in the same frame
        clear_all();
        req_a(16'h1234, 8'hA5, a1);
        req_a(16'h1235, 8'h3C, a2);
        wait_idle_a(t);
        chk("st_acc_t", a2 - a1, 65);
        chk("st_nbits", bits_a.size(), 40);
        chk("st_byte", pack_a(32, 8), 32'h3C);
        chk("st_nfall", fall_a.size(), 1);
        chk("st_nrise", rise_a.size(), 1);
        chk("st_ndone", dn_a.size(), 2);
        chk("st_done_t", dn_a.size() > 1 ? dn_a[1] - a2 : -1, 16);
        chk("st_rise_t", rise_a.size() > 0 ? rise_a[0] - a2 : -1, 25);

        // Non-sequential in HOLD: gap then self-started frame
        clear_all();
        req_a(16'h1234, 8'hA5, a1);
        req_a(16'h2000, 8'hFF, a2);
        rdy = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (dn_a.size() >= 2) break;
            if (ready_a) rdy++;
        end
        wait_idle_a(t);
        chk("ns_ready_hi", rdy, 0);
        chk("ns_nfall", fall_a.size(), 2);
        chk("ns_rise_t", rise_a.size() > 0 ? rise_a[0] - a2 : -1, 0);
        chk("ns_gap", fall_a.size() > 1 && rise_a.size() > 0 ?
            fall_a[1] - rise_a[0] : -1, 2);
        chk("ns_nbits", bits_a.size(), 64);
        chk("ns_word0", pack_a(0, 32), 32'h021234A5);
        chk("ns_word1", pack_a(32, 32), 32'h022000FF);
        chk("ns_done_t", dn_a.size() > 1 ? dn_a[1] - a2 : -1, 66);

        // 0xFFFF then 0x0000 must not stream
        clear_all();
        req_a(16'hFFFF, 8'h11, a1);
        req_a(16'h0000, 8'h22, a2);
        wait_idle_a(t);
        chk("wr_nfall", fall_a.size(), 2);
        chk("wr_nbits", bits_a.size(), 64);
        chk("wr_word0", pack_a(0, 32), 32'h02FFFF11);
        chk("wr_word1", pack_a(32, 32), 32'h02000022);

        // Streaming disabled: two separate frames
        clear_all();
        req_b(16'h0010, 8'h55, a1);
        req_b(16'h0011, 8'h66, a2);
        wait_idle_b();
        chk("h0_nfall", fall_b.size(), 2);
        chk("h0_ndone", dn_b.size(), 2);
        chk("h0_nbits", bits_b.size(), 64);
        chk("h0_word0", pack_b(0, 32), 32'h02001055);
        chk("h0_word1", pack_b(32, 32), 32'h02001166);
        chk("h0_rise_t", rise_b.size() > 0 ? rise_b[0] - a1 + 1 : -1, 65);
        chk("h0_gap_ge2", fall_b.size() > 1 && rise_b.size() > 0 ?
            (fall_b[1] - rise_b[0] >= 2) : 0, 1);

        // Asynchronous reset in the middle of ADRH
        clear_all();
        req_a(16'h4000, 8'h77, a1);
        while (ncyc < a1 + 21) @(negedge clk);
        #1;
        chk("mid_sck_hi", sck_a, 1);
        chk("mid_cs_lo", cs_a, 0);
        rst_n = 1'b0;
        #1;
        chk("ar_cs_n", cs_a, 1);
        chk("ar_sck", sck_a, 0);
        chk("ar_mosi", mosi_a, 0);
        chk("ar_busy", busy_a, 0);
        chk("ar_ready", ready_a, 1);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_all();
        req_a(16'h4001, 8'h88, a1);
        wait_idle_a(t);
        chk("ar_nbits", bits_a.size(), 32);
        chk("ar_word", pack_a(0, 32), 32'h02400188);
        chk("ar_cs_fall", fall_a.size() > 0 ? fall_a[0] - a1 + 1 : -1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dumbrv_spi_write.md
Name: dumbrv_spi_write

Overview:
- SPI write master for the external 23xx-style serial SRAM: issues WRITE (0x02), a 16-bit address and one data byte per request, in SPI mode 0.
- Consecutive writes to sequential addresses stream inside one chip-select frame.
- Write-side counterpart of the instruction/data SPI read path; used for store traffic and RAM preload.
- Owns its own SPI pins; bus sharing and arbitration sit outside this block.

Parameters:
- HOLD_CYCLES, 8: idle clk cycles CS stays asserted after a byte, waiting for a sequential follow-on write. 0 disables streaming.
- CS_GAP, 2: minimum clk cycles spi_cs_n is held high between frames (≥1).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- spi_mosi  output  1  serial data to SRAM, MSB first
- spi_cs_n  output  1  chip select, active low
- spi_sck  output  1  serial clock, idle low
- valid_i  input  1  write request
- addr_i  input  16  byte address
- data_i  input  8  byte to write
- ready_o  output  1  request accepted when valid_i && ready_o
- done_o  output  1  1-cycle pulse after the data byte's last SCK high phase
- busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - spi_cs_n=1, spi_sck=0, spi_mosi=0, ready_o=1, done_o=0, busy_o=0.
  - State is IDLE; the stored address is marked invalid.
  - Asserting reset mid-frame aborts the frame immediately; no partial byte is resumed afterwards.
- Bit timing:
  - Each bit takes 2 clk: a low phase (sck=0, mosi=bit) then a high phase (sck=1, mosi held).
  - The SRAM samples on the sck rising edge. One byte takes 16 clk.
- Acceptance:
  - A request is accepted on a clk edge where valid_i && ready_o. addr_i and data_i are registered at that edge.
  - valid_i may drop afterwards; the transfer always completes. There is no abort.
- States: IDLE, GAP, CMD, ADRH, ADRL, DATA, HOLD.
- IDLE (ready_o=1):
  - On accept at edge T, go to CMD.
  - Cycle T+1: cs_n=0, sck=0, mosi=0 (bit 7 of 0x02).
- CMD, ADRH, ADRL, DATA: each shifts 8 bits (0x02, addr[15:8], addr[7:0], data), then moves to the next state. ready_o=0 in all four.
- Fresh frame:
  - Last sck high phase is at T+64.
  - T+65: sck=0, done_o=1.
  - If HOLD_CYCLES>0, enter HOLD with cs_n=0. Otherwise enter GAP with cs_n=1.
- HOLD:
  - ready_o=1, cs_n=0, sck=0; a down-counter is loaded with HOLD_CYCLES.
  - Accept with addr_i == stored_addr+1 (no wrap): go to DATA only. The first data bit's low phase is on the next cycle; done_o fires 17 cycles after the accept edge. Stored address updates.
  - Accept with any other address, including 0xFFFF followed by 0x0000: cs_n=1 next cycle and go to GAP. The request is latched; after GAP, a fresh frame (CMD) starts with no further handshake.
  - Counter reaches 0 with no accept: cs_n=1 and go to GAP, with no pending request.
  - Accept in the same cycle the counter expires: the accept wins.
- GAP:
  - cs_n=1 for exactly CS_GAP cycles; ready_o=0.
  - Then go to CMD if a request is pending, else IDLE.
- Arithmetic and addressing:
  - stored_addr+1 is evaluated in 17 bits, so 0xFFFF never matches 0x0000.
  - No modulo addressing is done by this block.
- Outputs and ordering:
  - done_o fires once per byte written.
  - busy_o=1 whenever state≠IDLE. The frame is committed in the SRAM only after cs_n rises.

Test Plan:
- Fresh write, HOLD_CYCLES=8: valid addr=0x1234 data=0xA5 at T → cs_n falls at T+1; MOSI sampled on 32 sck rises = 0x02,0x12,0x34,0xA5; done_o at T+65; cs_n rises at T+74 (timeout); busy_o low after GAP.
- Streaming: after 0x1234/0xA5, accept 0x1235/0x3C in HOLD → cs_n stays low; exactly 8 further sck rises carrying 0x3C; done_o 17 cycles after accept.
- Non-sequential in HOLD: accept 0x2000/0xFF → cs_n high exactly CS_GAP=2 cycles; then a full frame 0x02,0x20,0x00,0xFF with no re-handshake; ready_o low during GAP and the frame.
- Wrap: write 0xFFFF/0x11, then 0x0000/0x22 inside HOLD → CS deasserts and a fresh frame with address 0x0000 is sent.
- HOLD_CYCLES=0: two back-to-back writes to 0x0010 and 0x0011 → two separate frames with a cs_n high gap of 2; no streaming.
- Reset mid-ADRH and valid drop: deasserting valid_i after accept still yields a full frame. Pulsing rst_n during ADRH → cs_n=1, sck=0, mosi=0 asynchronously. Next write to the same address+1 issues a fresh frame, not a stream.
